baccarat_round_ctrl: RTL and testbench

Sequences one baccarat round per start pulse over the existing card/score datapath: pcard1-3 and dcard1-3 registers with score logic.
- Fetches each card from the card source (shoe/dealcard block) with a req/valid handshake and strobes the matching load enable.
- Applies natural and third-card rules, then drives the win lights.
- Keeps saturating player/dealer/tie tallies across rounds.

---
 rtl/baccarat_round_ctrl_if.sv | 32 +++
 rtl/baccarat_round_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_baccarat_round_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/baccarat_round_ctrl_if.sv
// Card-source / datapath connection for the baccarat round controller.
//   master (controller): drives card_req, the six card load strobes and
//                        clear_cards; receives card_valid and the scores.
//   slave  (shoe + card/score datapath): the mirror image.
// The card data bus itself runs from the shoe straight into the datapath
// and is not seen by the controller.
interface baccarat_round_ctrl_if;
    logic       card_req;
    logic       card_valid;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       clear_cards;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;

    modport master (
        output card_req, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3, clear_cards,
        input  card_valid, pscore, dscore, pcard3
    );

    modport slave (
        input  card_req, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3, clear_cards,
        output card_valid, pscore, dscore, pcard3
    );
endinterface

// File: rtl/baccarat_round_ctrl.sv
// Baccarat round sequencer: one round per start pulse. Fetches cards with a
// req/valid handshake, applies the natural and third-card rules, drives the
// win lights and keeps saturating player/dealer/tie tallies.
// Ports:
//   slow_clock        sole clock, rising edge
//   resetb            asynchronous reset, active high
//   start             begin a round (honoured only in IDLE or DONE)
//   dp                card source / datapath connection (master side)
//   busy, done        round in progress / round finished
//   player_win_light, dealer_win_light   result, both high = tie
//   player_wins, dealer_wins, ties       saturating tallies
module baccarat_round_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic                  slow_clock,
    input  logic                  resetb,
    input  logic                  start,
    baccarat_round_ctrl_if.master dp,
    output logic                  busy,
    output logic                  done,
    output logic                  player_win_light,
    output logic                  dealer_win_light,
    output logic [CNT_W-1:0]      player_wins,
    output logic [CNT_W-1:0]      dealer_wins,
    output logic [CNT_W-1:0]      ties
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CLR      = 4'd1,
        S_DEAL_P1  = 4'd2,
        S_DEAL_D1  = 4'd3,
        S_DEAL_P2  = 4'd4,
        S_DEAL_D2  = 4'd5,
        S_EVAL_NAT = 4'd6,
        S_DEAL_P3  = 4'd7,
        S_EVAL_D3  = 4'd8,
        S_DEAL_D3  = 4'd9,
        S_SCORE    = 4'd10,
        S_DONE     = 4'd11
    } state_e;

    state_e           state_q, state_d;
    logic             card_req_q, card_req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             plight_q, plight_d;
    logic             dlight_q, dlight_d;
    logic [CNT_W-1:0] pwins_q, pwins_d;
    logic [CNT_W-1:0] dwins_q, dwins_d;
    logic [CNT_W-1:0] ties_q, ties_d;
    logic             take_s;
    logic             lp1_s, lp2_s, lp3_s, ld1_s, ld2_s, ld3_s, clear_s;

    function automatic logic is_deal(input state_e s);
        logic r;
        case (s)
            S_DEAL_P1, S_DEAL_D1, S_DEAL_P2,
            S_DEAL_D2, S_DEAL_P3, S_DEAL_D3: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

    // Dealer third-card table for the case where the player drew a third card.
    function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] p3);
        logic r;
        case (ds)
            4'd0, 4'd1, 4'd2: r = 1'b1;
            4'd3:             r = (p3 != 4'd8);
            4'd4:             r = (p3 >= 4'd2) && (p3 <= 4'd7);
            4'd5:             r = (p3 >= 4'd4) && (p3 <= 4'd7);
            4'd6:             r = (p3 >= 4'd6) && (p3 <= 4'd7);
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // card_req_q mirrors "state is a DEAL state", so a card is taken in
    // exactly the cycle the source presents it while we are asking.
    assign take_s = card_req_q && dp.card_valid;

    // Next-state, strobe, light and tally logic.
    always_comb begin
        state_d  = state_q;
        plight_d = plight_q;
        dlight_d = dlight_q;
        pwins_d  = pwins_q;
        dwins_d  = dwins_q;
        ties_d   = ties_q;
        lp1_s    = 1'b0;
        lp2_s    = 1'b0;
        lp3_s    = 1'b0;
        ld1_s    = 1'b0;
        ld2_s    = 1'b0;
        ld3_s    = 1'b0;
        clear_s  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_CLR;
                else       state_d = state_q;
            end
            S_CLR: begin
                clear_s  = 1'b1;
                plight_d = 1'b0;
                dlight_d = 1'b0;
                state_d  = S_DEAL_P1;
            end
            S_DEAL_P1: begin
                lp1_s = take_s;
                if (take_s) state_d = S_DEAL_D1;
                else        state_d = state_q;
            end
            S_DEAL_D1: begin
                ld1_s = take_s;
                if (take_s) state_d = S_DEAL_P2;
                else        state_d = state_q;
            end
            S_DEAL_P2: begin
                lp2_s = take_s;
                if (take_s) state_d = S_DEAL_D2;
                else        state_d = state_q;
            end
            S_DEAL_D2: begin
                ld2_s = take_s;
                if (take_s) state_d = S_EVAL_NAT;
                else        state_d = state_q;
            end
            S_EVAL_NAT: begin
                if ((dp.pscore >= 4'd8) || (dp.dscore >= 4'd8)) state_d = S_SCORE;
                else if (dp.pscore <= 4'd5)                       state_d = S_DEAL_P3;
                else if (dp.dscore <= 4'd5)                       state_d = S_DEAL_D3;
                else                                              state_d = S_SCORE;
            end
            S_DEAL_P3: begin
                lp3_s = take_s;
                if (take_s) state_d = S_EVAL_D3;
                else        state_d = state_q;
            end
            S_EVAL_D3: begin
                if (dealer_draws(dp.dscore, dp.pcard3)) state_d = S_DEAL_D3;
                else                                    state_d = S_SCORE;
            end
            S_DEAL_D3: begin
                ld3_s = take_s;
                if (take_s) state_d = S_SCORE;
                else        state_d = state_q;
            end
            S_SCORE: begin
                if (dp.pscore > dp.dscore) begin
                    plight_d = 1'b1;
                    pwins_d  = sat_inc(pwins_q);
                end else if (dp.dscore > dp.pscore) begin
                    dlight_d = 1'b1;
                    dwins_d  = sat_inc(dwins_q);
                end else begin
                    plight_d = 1'b1;
                    dlight_d = 1'b1;
                    ties_d   = sat_inc(ties_q);
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        card_req_d = is_deal(state_d);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    // State and registered-output flops.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            state_q    <= S_IDLE;
            card_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            plight_q   <= 1'b0;
            dlight_q   <= 1'b0;
            pwins_q    <= {CNT_W{1'b0}};
            dwins_q    <= {CNT_W{1'b0}};
            ties_q     <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            card_req_q <= card_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            plight_q   <= plight_d;
            dlight_q   <= dlight_d;
            pwins_q    <= pwins_d;
            dwins_q    <= dwins_d;
            ties_q     <= ties_d;
        end
    end

    assign dp.card_req       = card_req_q;
    assign dp.load_pcard1    = lp1_s;
    assign dp.load_pcard2    = lp2_s;
    assign dp.load_pcard3    = lp3_s;
    assign dp.load_dcard1    = ld1_s;
    assign dp.load_dcard2    = ld2_s;
    assign dp.load_dcard3    = ld3_s;
    assign dp.clear_cards    = clear_s;
    assign busy              = busy_q;
    assign done              = done_q;
    assign player_win_light  = plight_q;
    assign dealer_win_light  = dlight_q;
    assign player_wins       = pwins_q;
    assign dealer_wins       = dwins_q;
    assign ties              = ties_q;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Bench for baccarat_round_ctrl: plays shoe + card/score datapath, predicts
// each round from the baccarat rules applied to the dealt cards.
module tb_baccarat_round_ctrl;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             slow_clock = 1'b0;
    logic             resetb;
    logic             start;
    logic             busy, done, plight, dlight;
    logic [CNT_W-1:0] pwins, dwins, tiesc;
    logic [3:0]       card_bus;
    logic [3:0]       pc1, pc2, pc3, dc1, dc2, dc3;

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    int shoe[8];
    int shoe_k;
    int log_q[$];
    int m_pw, m_dw, m_tw;

    baccarat_round_ctrl_if dp_if();

    baccarat_round_ctrl #(.CNT_W(CNT_W)) dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .start            (start),
        .dp               (dp_if),
        .busy             (busy),
        .done             (done),
        .player_win_light (plight),
        .dealer_win_light (dlight),
        .player_wins      (pwins),
        .dealer_wins      (dwins),
        .ties             (tiesc)
    );

    always #5 slow_clock = ~slow_clock;

    // Card registers of the datapath: loaded from the card bus on strobes.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            {pc1, pc2, pc3, dc1, dc2, dc3} <= '0;
        end else if (dp_if.clear_cards) begin
            {pc1, pc2, pc3, dc1, dc2, dc3} <= '0;
        end else begin
            if (dp_if.load_pcard1) pc1 <= card_bus;
            if (dp_if.load_pcard2) pc2 <= card_bus;
            if (dp_if.load_pcard3) pc3 <= card_bus;
            if (dp_if.load_dcard1) dc1 <= card_bus;
            if (dp_if.load_dcard2) dc2 <= card_bus;
            if (dp_if.load_dcard3) dc3 <= card_bus;
        end
    end

    function automatic logic [3:0] hand(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return 4'((32'(a) + 32'(b) + 32'(c)) % 10);
    endfunction

    assign dp_if.pscore = hand(pc1, pc2, pc3);
    assign dp_if.dscore = hand(dc1, dc2, dc3);
    assign dp_if.pcard3 = pc3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic int enc(input int q[$]);
        int r = 0;
        foreach (q[i]) r = r * 8 + q[i];
        return r;
    endfunction

    // One clock: drive inputs at the falling edge, log the strobes seen.
    // Strobe codes: 0 clear, 1/2/3 player cards, 4/5/6 dealer cards.
    task automatic step(input int vpct, input logic st);
        int n;
        @(negedge slow_clock);
        start = st;
        dp_if.card_valid = (32'($urandom_range(99)) < vpct);
        card_bus = 4'(shoe[shoe_k]);
        #1;
        n = int'(dp_if.load_pcard1) + int'(dp_if.load_pcard2) + int'(dp_if.load_pcard3)
          + int'(dp_if.load_dcard1) + int'(dp_if.load_dcard2) + int'(dp_if.load_dcard3)
          + int'(dp_if.clear_cards);
        if (n > 1) overlap++;
        if (dp_if.clear_cards) log_q.push_back(0);
        if (dp_if.load_pcard1) begin log_q.push_back(1); shoe_k++; end
        if (dp_if.load_pcard2) begin log_q.push_back(2); shoe_k++; end
        if (dp_if.load_pcard3) begin log_q.push_back(3); shoe_k++; end
        if (dp_if.load_dcard1) begin log_q.push_back(4); shoe_k++; end
        if (dp_if.load_dcard2) begin log_q.push_back(5); shoe_k++; end
        if (dp_if.load_dcard3) begin log_q.push_back(6); shoe_k++; end
    endtask

    task automatic set_shoe(input int a, input int b, input int c, input int d, input int e, input int f);
        shoe = '{a, b, c, d, e, f, 1, 1};
    endtask

    task automatic rand_shoe();
        foreach (shoe[i]) shoe[i] = int'($urandom_range(1, 10));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_done"},   32'(done), 32'd0);
        chk({tag, "_lights"}, 32'({plight, dlight}), 32'd0);
        chk({tag, "_tallies"}, 32'({pwins, dwins, tiesc}), 32'd0);
        chk({tag, "_req"},    32'(dp_if.card_req), 32'd0);
        chk({tag, "_strobes"}, 32'({dp_if.load_pcard1, dp_if.load_pcard2, dp_if.load_pcard3,
                                     dp_if.load_dcard1, dp_if.load_dcard2, dp_if.load_dcard3,
                                     dp_if.clear_cards}), 32'd0);
    endtask

    // Play one round from the current shoe; stall_at >= 0 starves the source
    // for 20 cycles once that many strobes have been logged.
    task automatic run_round(input int vpct, input int stall_at);
        int  p, d, n, p3, cyc;
        bit  pd, dd, bad, bad_stall, stalled;
        int  exp_log[$];
        p = (shoe[0] + shoe[2]) % 10;
        d = (shoe[1] + shoe[3]) % 10;
        exp_log = '{0, 1, 4, 2, 5};
        n = 4; pd = 0; dd = 0;
        if (p < 8 && d < 8) begin
            if (p <= 5) begin
                pd = 1; p3 = shoe[4]; n = 5;
                dd = (d <= 2) || (d == 3 && p3 != 8) || (d == 4 && p3 >= 2 && p3 <= 7)
                  || (d == 5 && p3 >= 4 && p3 <= 7) || (d == 6 && p3 >= 6 && p3 <= 7);
                p = (p + p3) % 10;
            end else begin
                dd = (d <= 5);
            end
            if (dd) d = (d + shoe[n]) % 10;
        end
        if (pd) exp_log.push_back(3);
        if (dd) exp_log.push_back(6);
        if (p > d) m_pw++; else if (d > p) m_dw++; else m_tw++;

        log_q.delete(); shoe_k = 0; bad = 0; bad_stall = 0; stalled = 0; cyc = 0;
        step(vpct, 1'b1);
        do begin
            if (stall_at >= 0 && !stalled && log_q.size() == stall_at) begin
                stalled = 1;
                repeat (20) begin
                    step(0, 1'($urandom_range(1)));
                    if (dp_if.card_req !== 1'b1 || log_q.size() != stall_at || done !== 1'b0) bad_stall = 1;
                end
            end else begin
                step(vpct, 1'b0);
                cyc++;
            end
            if (!done && busy !== 1'b1) bad = 1;
            if (!done && cyc >= 2 && (plight | dlight)) bad = 1;
        end while (done !== 1'b1 && cyc < 400);

        chk("round_done", 32'(done), 32'd1);
        chk("in_round", 32'(bad), 32'd0);
        if (stall_at >= 0) chk("stall_hold", 32'(bad_stall), 32'd0);
        if (vpct == 100 && stall_at < 0) chk("latency", cyc, 8 + (pd ? 2 : 0) + (dd ? 1 : 0));
        chk("strobe_cnt", log_q.size(), exp_log.size());
        chk("strobe_seq", enc(log_q), enc(exp_log));
        chk("p_light", 32'(plight), 32'(p >= d));
        chk("d_light", 32'(dlight), 32'(d >= p));
        chk("player_wins", 32'(pwins), sat(m_pw));
        chk("dealer_wins", 32'(dwins), sat(m_dw));
        chk("ties", 32'(tiesc), sat(m_tw));
        chk("busy_end", 32'(busy), 32'd0);
        chk("req_end", 32'(dp_if.card_req), 32'd0);
    endtask

    initial begin
        resetb = 1'b1;
        start = 1'b0;
        dp_if.card_valid = 1'b0;
        card_bus = 4'd0;
        shoe_k = 0;
        m_pw = 0; m_dw = 0; m_tw = 0;
        rand_shoe();
        repeat (3) @(posedge slow_clock);
        #1 chk_quiet("in_reset");
        @(negedge slow_clock) resetb = 1'b0;
        #1 chk_quiet("after_reset");

        // Directed rounds with the source always ready.
        set_shoe(3, 1, 5, 2, 9, 9); run_round(100, -1);  // p8 d3 natural
        set_shoe(4, 4, 5, 5, 9, 9); run_round(100, -1);  // natural tie 9-9
        set_shoe(2, 1, 2, 2, 8, 5); run_round(100, -1);  // p4, p3=8, d3 stands
        set_shoe(2, 1, 2, 2, 2, 5); run_round(100, -1);  // p4, p3=2, d3 draws
        set_shoe(2, 3, 2, 3, 5, 1); run_round(100, -1);  // d6, p3=5 stands
        set_shoe(3, 2, 3, 3, 4, 1); run_round(100, -1);  // p6 d5 dealer draws
        set_shoe(3, 3, 4, 3, 1, 1); run_round(100, -1);  // p7 d6 straight to score

        // Starved source in DEAL_D1, with start pulses while busy.
        rand_shoe(); run_round(100, 2);

        // Reset in the middle of DEAL_P2.
        rand_shoe(); log_q.delete(); shoe_k = 0;
        step(100, 1'b1);
        for (int g = 0; g < 20 && log_q.size() < 3; g++) step(100, 1'b0);
        step(0, 1'b0);
        chk("p2_req", 32'(dp_if.card_req), 32'd1);
        #2 resetb = 1'b1;
        #1 chk_quiet("mid_reset");
        m_pw = 0; m_dw = 0; m_tw = 0;
        @(negedge slow_clock) resetb = 1'b0;

        // Saturation: four player wins on a 2-bit tally.
        repeat (4) begin set_shoe(3, 1, 5, 2, 9, 9); run_round(100, -1); end
        chk("pw_saturated", 32'(pwins), 32'd3);

        // Random rounds with a random source readiness.
        for (int r = 0; r < 60; r++) begin
            rand_shoe();
            run_round((r % 3 == 0) ? 100 : int'($urandom_range(30, 100)), -1);
        end

        chk("no_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
